// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: load/store opcodes, FSM states, byte enables.
package mem_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction
endpackage

// File: rtl/mem_load_ext.sv
// Load-data lane select and sign/zero extension of the returned memory word.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  op,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    result   = word;
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data-memory transaction, load alignment, MEM/WB register.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses skip memory and raise mem_exc.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       exe_out,
  input  logic [31:0]       exe_inst,
  input  logic [31:0]       exe_pc,
  input  logic              exe_valid,
  input  logic [31:0]       exe_rt,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic [31:0]       mem_out,
  output logic [31:0]       mem_inst,
  output logic [31:0]       mem_pc,
  output logic              mem_valid,
  output logic              mem_exc
);
  state_e      state_q, state_d;
  logic [31:0] mem_out_q, mem_out_d, mem_inst_q, mem_inst_d, mem_pc_q, mem_pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_valid_q, mem_valid_d, mem_exc_q, mem_exc_d;

  logic [5:0]  op;
  logic        is_ld, is_st, is_mem, misalign, go;
  logic [31:0] ld_data;

  assign op     = exe_inst[31:26];
  assign is_ld  = op_is_load(op);
  assign is_st  = op_is_store(op);
  assign is_mem = (is_ld | is_st) & exe_valid;

`ifdef MEM_ALIGN_TRAP_EN
  assign misalign = is_mem &&
    ((((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && exe_out[0]) ||
     (((op == OP_LW) || (op == OP_SW)) && (exe_out[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign go = is_mem & ~misalign;

  mem_load_ext u_ext (
    .addr_lo (exe_out[1:0]),
    .op      (op),
    .word    (rdata_q),
    .result  (ld_data)
  );

  // Memory port is driven from stable EXE/MEM registers; only req/we depend on state.
  assign dm_req    = (state_q == REQ);
  assign dm_we     = dm_req & is_st;
  assign dm_addr   = {exe_out[ADDR_W-1:2], 2'b00};
  assign mem_stall = ((state_q == IDLE) & go) | (state_q == REQ);

  always_comb begin
    dm_be    = BE_WORD;
    dm_wdata = exe_rt;
    case (op)
      OP_SB: begin
        dm_be    = BE_B0 << exe_out[1:0];
        dm_wdata = {4{exe_rt[7:0]}};
      end
      OP_SH: begin
        dm_be    = exe_out[1] ? BE_HI : BE_LO;
        dm_wdata = {2{exe_rt[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_out_d   = mem_out_q;
    mem_inst_d  = mem_inst_q;
    mem_pc_d    = mem_pc_q;
    mem_valid_d = mem_valid_q;
    mem_exc_d   = mem_exc_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = REQ;
          mem_valid_d = 1'b0;
        end else begin
          mem_out_d   = exe_out;
          mem_inst_d  = exe_inst;
          mem_pc_d    = exe_pc;
          mem_valid_d = exe_valid;
          mem_exc_d   = misalign;
        end
      end
      REQ: begin
        mem_valid_d = 1'b0;
        if (dm_ack) begin
          rdata_d = dm_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_out_d   = is_ld ? ld_data : exe_out;
        mem_inst_d  = exe_inst;
        mem_pc_d    = exe_pc;
        mem_valid_d = 1'b1;
        mem_exc_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_out_q   <= '0;
      mem_inst_q  <= '0;
      mem_pc_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_exc_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_out_q   <= mem_out_d;
      mem_inst_q  <= mem_inst_d;
      mem_pc_q    <= mem_pc_d;
      mem_valid_q <= mem_valid_d;
      mem_exc_q   <= mem_exc_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_out   = mem_out_q;
  assign mem_inst  = mem_inst_q;
  assign mem_pc    = mem_pc_q;
  assign mem_valid = mem_valid_q;
  assign mem_exc   = mem_exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB results, a negedge monitor checks them.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exe_out, exe_inst, exe_pc, exe_rt;
  logic        exe_valid;
  logic        dm_req, dm_we, dm_ack;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, mem_valid, mem_exc;
  logic [31:0] mem_out, mem_inst, mem_pc;

  typedef struct {
    logic [31:0] out;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .exe_out(exe_out), .exe_inst(exe_inst), .exe_pc(exe_pc),
    .exe_valid(exe_valid), .exe_rt(exe_rt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .mem_out(mem_out), .mem_inst(mem_inst),
    .mem_pc(mem_pc), .mem_valid(mem_valid), .mem_exc(mem_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && mem_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got out=%h inst=%h, expected none", mem_out, mem_inst);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({mem_out, mem_inst, mem_pc, mem_exc} !== {e.out, e.inst, e.pc, e.exc}) begin
          n_bad++;
          $display("FAIL mem_result: got out=%h inst=%h pc=%h exc=%b, expected out=%h inst=%h pc=%h exc=%b",
                   mem_out, mem_inst, mem_pc, mem_exc, e.out, e.inst, e.pc, e.exc);
        end
      end
    end
  end

  task automatic present(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic valid);
    exe_inst  = {op, 26'h012_3456};
    exe_out   = addr;
    exe_rt    = rt;
    exe_valid = valid;
    pc_ctr    = pc_ctr + 32'd4;
    exe_pc    = pc_ctr;
  endtask

  // Single-cycle op: expects no stall and output the next edge.
  task automatic pass_op(input logic [5:0] op, input logic [31:0] addr, input logic valid,
                         input logic exp_exc);
    @(negedge clk);
    present(op, addr, 32'h0, valid);
    if (valid) sb_q.push_back('{addr, exe_inst, exe_pc, exp_exc});
    #1;
    chk("pass_stall", {31'h0, mem_stall}, 32'h0);
    chk("pass_req", {31'h0, dm_req}, 32'h0);
    @(posedge clk);
  endtask

  task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int nreq,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_out, input int exp_stall);
    int reqs, stalls;
    bit acked;
    reqs = 0; stalls = 0; acked = 0;
    @(negedge clk);
    present(op, addr, rt, 1'b1);
    sb_q.push_back('{exp_out, exe_inst, exe_pc, 1'b0});
    for (int c = 0; c < 20 && !acked; c++) begin
      #1;
      if (mem_stall) stalls++;
      if (dm_req) begin
        reqs++;
        chk("req_bubble", {31'h0, mem_valid}, 32'h0);
        if (reqs == 1) begin
          chk("dm_addr", dm_addr, exp_addr);
          chk("dm_we", {31'h0, dm_we}, {31'h0, exp_we});
          if (exp_we) begin
            chk("dm_be", {28'h0, dm_be}, {28'h0, exp_be});
            chk("dm_wdata", dm_wdata, exp_wdata);
          end
        end
        if (reqs == nreq) begin
          dm_ack   = 1'b1;
          dm_rdata = rdata;
          acked    = 1'b1;
        end
      end
      @(posedge clk);
      #1 dm_ack = 1'b0;
      dm_rdata = 32'h0;
      if (!acked) @(negedge clk);
    end
    if (!acked) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: got %0d req cycles, expected %0d", reqs, nreq);
    end
    @(negedge clk);
    #1;
    chk("done_stall", {31'h0, mem_stall}, 32'h0);
    chk("done_req", {31'h0, dm_req}, 32'h0);
    chk("stall_cycles", stalls, exp_stall);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    exe_out = 32'h0; exe_inst = 32'h0; exe_pc = 32'h0; exe_rt = 32'h0; exe_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {mem_valid, mem_exc, dm_req, mem_stall}, 32'h0);
    chk("rst_mem_out", mem_out, 32'h0);
    rst = 1'b0;

    // ADDU pass-through, then an invalid LW that must not stall.
    pass_op(6'h00, 32'h0000_1234, 1'b1, 1'b0);
    pass_op(6'h23, 32'h0000_0040, 1'b0, 1'b0);

    mem_op(6'h20, 32'h103, 32'h0, 32'h80FF_FF00, 2, 32'h100, 4'b0000, 1'b0, 32'h0, 32'hFFFF_FF80, 3);
    mem_op(6'h29, 32'h202, 32'hABCD_1234, 32'h0, 1, 32'h200, 4'b1100, 1'b1, 32'h1234_1234, 32'h202, 2);
    mem_op(6'h28, 32'h101, 32'h0000_00A5, 32'h0, 1, 32'h100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h101, 2);
    mem_op(6'h2B, 32'h020, 32'hCAFE_F00D, 32'h0, 3, 32'h020, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h020, 4);
    mem_op(6'h21, 32'h012, 32'h0, 32'h8001_0000, 1, 32'h010, 4'b0000, 1'b0, 32'h0, 32'hFFFF_8001, 2);
    mem_op(6'h24, 32'h102, 32'h0, 32'h00C3_0000, 1, 32'h100, 4'b0000, 1'b0, 32'h0, 32'h0000_00C3, 2);
    // Back-to-back LHU / LW.
    mem_op(6'h25, 32'h010, 32'h0, 32'h0000_8001, 1, 32'h010, 4'b0000, 1'b0, 32'h0, 32'h0000_8001, 2);
    mem_op(6'h23, 32'h014, 32'h0, 32'hDEAD_BEEF, 1, 32'h014, 4'b0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2);

    // Reset during the second REQ cycle of an LW; a late ack must be ignored.
    @(negedge clk);
    present(6'h23, 32'h300, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("abort_req_up", {31'h0, dm_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1; exe_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", {31'h0, dm_req}, 32'h0);
    chk("abort_valid", {31'h0, mem_valid}, 32'h0);
    chk("abort_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("late_ack_req", {31'h0, dm_req}, 32'h0);
    chk("late_ack_valid", {31'h0, mem_valid}, 32'h0);

    // Misaligned LW.
`ifdef MEM_ALIGN_TRAP_EN
    pass_op(6'h23, 32'h006, 1'b1, 1'b1);
`else
    mem_op(6'h23, 32'h006, 32'h0, 32'h1122_3344, 1, 32'h004, 4'b0000, 1'b0, 32'h0, 32'h1122_3344, 2);
`endif

    @(negedge clk);
    exe_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting directly downstream of the EXE/MEM register. It consumes the registered ALU result, instruction and PC from EXE and decodes the load/store opcode. It runs a request/acknowledge transaction on the data-memory port, aligns and extends load data, and registers result, instruction and PC toward write-back. While a memory transaction is outstanding it asserts `mem_stall` to freeze the upstream pipeline registers.

## Interface
- `ADDR_W`, 32, data-memory address width; `exe_out[ADDR_W-1:0]` is the effective address.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `exe_out`  in  32  registered ALU result / effective address
- `exe_inst`  in  32  registered instruction
- `exe_pc`  in  32  registered PC
- `exe_valid`  in  1  EXE/MEM register holds a live instruction
- `exe_rt`  in  32  store data (rt value)
- `dm_req`  out  1  memory request, held until `dm_ack`
- `dm_we`  out  1  1 = store
- `dm_be`  out  4  byte enables, bit i = byte lane i (little-endian)
- `dm_addr`  out  ADDR_W  word address, `{exe_out[ADDR_W-1:2],2'b00}`
- `dm_wdata`  out  32  store data, lane-replicated
- `dm_rdata`  in  32  read word, valid with `dm_ack`
- `dm_ack`  in  1  transaction complete
- `mem_stall`  out  1  freeze upstream registers (`we` low)
- `mem_out`, `mem_inst`, `mem_pc`  out  32 each  registered stage result, instruction and PC
- `mem_valid`  out  1  outputs hold a live instruction
- `mem_exc`  out  1  misaligned-access flag (see Configuration)

## Operation
- Opcode `exe_inst[31:26]`: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. `is_mem` = one of these AND `exe_valid`.
- FSM states:
  - IDLE: if `is_mem`, go to REQ. Otherwise capture the pass-through on this edge: `mem_out=exe_out`, `mem_valid=exe_valid`.
  - REQ: hold `dm_req`=1 with stable addr, we, be and wdata. On `dm_ack`, latch `dm_rdata` into the hold register and go to DONE.
  - DONE: capture the output (load → extracted data; store → `exe_out`), set `mem_valid`=1, go to IDLE.
- `mem_stall` = (IDLE AND `is_mem`) OR REQ. It is low in DONE, so upstream advances on the DONE edge.
- While the stage is in REQ, or in IDLE going to REQ, the output register loads a bubble (`mem_valid`=0, other outputs hold).
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{rt[7:0]}}
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}
  - SW: be = 1111
- Loads: the byte is selected by addr[1:0] and the half by addr[1]. LB and LH sign-extend; LBU and LHU zero-extend.
- `dm_ack` outside REQ is ignored. `dm_req` is never asserted outside REQ.

## Timing
- Non-memory instruction: 1 cycle, with `mem_out` valid the edge after it is presented.
- Memory instruction: at least 3 cycles (IDLE→REQ→DONE) plus ack wait. With `dm_ack` in the first REQ cycle, outputs are valid 3 edges after presentation.
- `dm_req` is registered-state driven; there is no combinational path from `dm_ack` to `dm_req` or to `mem_stall`.
- Reset (including mid-REQ): state IDLE, `dm_req`=0, `mem_stall`=0, all `mem_*` outputs and `mem_exc`=0. An outstanding transaction is abandoned; memory must tolerate a dropped request.
- Back-to-back memory instructions: DONE→IDLE, and the next op raises `mem_stall` in that IDLE cycle.

## Configuration
- `MEM_ALIGN_TRAP_EN` defined:
  - LH, LHU and SH with addr[0]=1, and LW and SW with addr[1:0]≠0, issue no request and pass through in 1 cycle.
  - These set `mem_exc`=1 and `mem_out=exe_out` with `mem_valid`=1.
- Undefined:
  - `mem_exc` is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

## Structure
- Package `mem_pkg`: opcode constants, FSM state enum (IDLE/REQ/DONE), byte-enable constants.
- Sub-module `mem_load_ext`: combinational lane select and sign/zero extension (addr[1:0], opcode, word → 32-bit result).

## Test plan
- ADDU, exe_out=0x1234, valid → next edge `mem_out`=0x1234, `mem_valid`=1, `mem_stall` never high.
- LB addr 0x103, `dm_rdata`=0x80FF_FF00, ack after 2 REQ cycles → `dm_addr`=0x100, `mem_out`=0xFFFF_FF80, stall high for 3 cycles.
- SH addr 0x202, rt=0xABCD_1234 → `dm_be`=1100, `dm_wdata`=0x1234_1234, `dm_we`=1.
- LW, `rst` pulsed in second REQ cycle → next edge `dm_req`=0, `mem_valid`=0, state IDLE; a late `dm_ack` is ignored.
- LHU 0x10 then LW 0x14 back-to-back, rdata 0x0000_8001 / 0xDEAD_BEEF → `mem_out` 0x0000_8001 then 0xDEAD_BEEF, one bubble each.
- `MEM_ALIGN_TRAP_EN` set, LW addr 0x6 → no `dm_req`, `mem_exc`=1 one edge later. Without the macro → request at 0x4.
